// File: rtl/psum_wr_sched_pkg.sv
// Shared constants, FSM encoding and popcount for the PSUM write scheduler.
package psum_wr_sched_pkg;

  localparam int MAC_NUM   = 27;
  localparam int PSUM_NUM  = 9;
  localparam int MAC_ID_W  = 5;
  localparam int PSUM_ID_W = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [PSUM_NUM-1:0] v
  );
    logic [CNT_W-1:0] s;
    s = '0;
    for (int k = 0; k < PSUM_NUM; k++)
      s = s + CNT_W'(v[k]);
    return s;
  endfunction

endpackage

// File: rtl/psum_wr_sched_rr_pick.sv
// Per-bank picker: round-robin from ptr, or lowest index when
// PSUM_WR_SCHED_FIXPRI_EN is defined.
module rr_pick
  import psum_wr_sched_pkg::*;
(
  input  logic [MAC_NUM-1:0]  req,
  input  logic [MAC_ID_W-1:0] ptr,
  output logic [MAC_NUM-1:0]  gnt,
  output logic [MAC_ID_W-1:0] idx,
  output logic                vld
);

`ifdef PSUM_WR_SCHED_FIXPRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    for (int k = MAC_NUM-1; k >= 0; k--)
      if (req[k]) idx = MAC_ID_W'(k);
  end
`else
  logic [MAC_NUM-1:0]  rot;
  logic [MAC_ID_W-1:0] off;
  logic [MAC_ID_W:0]   sum;

  // rot[k] is req[(ptr+k) mod MAC_NUM]
  assign rot = MAC_NUM'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int k = MAC_NUM-1; k >= 0; k--)
      if (rot[k]) off = MAC_ID_W'(k);
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (MAC_ID_W+1)'(MAC_NUM))
             ? MAC_ID_W'(sum - (MAC_ID_W+1)'(MAC_NUM))
             : sum[MAC_ID_W-1:0];
`endif

  assign vld = |req;
  assign gnt = vld ? (MAC_NUM'(1) << idx) : '0;

endmodule

// File: rtl/psum_wr_sched.sv
// PSUM bank write scheduler with block write counter.
// Build option: PSUM_WR_SCHED_FIXPRI_EN selects fixed-priority banks.
module psum_wr_sched
  import psum_wr_sched_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          blk_sta,
  input  logic [CNT_W-1:0]              blk_len,
  input  logic [MAC_NUM-1:0]            mac_req,
  input  logic [PSUM_ID_W*MAC_NUM-1:0]  mac_idpsum,
  input  logic [PSUM_NUM-1:0]           psum_rdy,
  output logic [MAC_NUM-1:0]            mac_gnt,
  output logic [PSUM_NUM-1:0]           psum_wr_en,
  output logic [MAC_ID_W*PSUM_NUM-1:0]  psum_wr_sel,
  output logic                          blk_fnh,
  output logic                          err_badid,
  output logic                          err_over
);

  state_t              state;
  logic [CNT_W-1:0]    len;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_add;
  logic [CNT_W:0]      sum;
  logic                arb_en;
  logic                badid;
  logic [MAC_NUM-1:0]  cand [PSUM_NUM];
  logic [MAC_NUM-1:0]  pgnt [PSUM_NUM];
  logic [MAC_ID_W-1:0] pidx [PSUM_NUM];
  logic [MAC_ID_W-1:0] ptr  [PSUM_NUM];
  logic [PSUM_NUM-1:0] pvld;
  logic [MAC_NUM-1:0]  gnt_nxt;
  logic [PSUM_NUM-1:0] wr_nxt;

  assign sum     = {1'b0, cnt} + {1'b0, popcnt(psum_wr_en)};
  assign cnt_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  // stop granting once in-flight writes already reach the length
  assign arb_en  = (state == RUN) && (cnt_add < len);

  always_comb begin
    logic [PSUM_ID_W-1:0] bid;
    badid = 1'b0;
    for (int b = 0; b < PSUM_NUM; b++)
      cand[b] = '0;
    for (int i = 0; i < MAC_NUM; i++) begin
      bid = mac_idpsum[PSUM_ID_W*i +: PSUM_ID_W];
      if (mac_req[i] && bid >= PSUM_ID_W'(PSUM_NUM))
        badid = 1'b1;
      for (int b = 0; b < PSUM_NUM; b++)
        cand[b][i] = mac_req[i] & ~mac_gnt[i]
                   & (bid == PSUM_ID_W'(b));
    end
  end

  for (genvar b = 0; b < PSUM_NUM; b++) begin : g_bank
    rr_pick u_pick (
      .req (cand[b]),
      .ptr (ptr[b]),
      .gnt (pgnt[b]),
      .idx (pidx[b]),
      .vld (pvld[b])
    );
  end

  always_comb begin
    gnt_nxt = '0;
    wr_nxt  = '0;
    for (int b = 0; b < PSUM_NUM; b++)
      if (arb_en && psum_rdy[b] && pvld[b]) begin
        wr_nxt[b] = 1'b1;
        gnt_nxt   = gnt_nxt | pgnt[b];
      end
  end

`ifdef PSUM_WR_SCHED_FIXPRI_EN
  always_comb
    for (int b = 0; b < PSUM_NUM; b++)
      ptr[b] = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < PSUM_NUM; b++)
        ptr[b] <= '0;
    end else begin
      for (int b = 0; b < PSUM_NUM; b++)
        if (wr_nxt[b])
          ptr[b] <= (pidx[b] == MAC_ID_W'(MAC_NUM-1))
                  ? '0 : pidx[b] + MAC_ID_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      cnt         <= '0;
      mac_gnt     <= '0;
      psum_wr_en  <= '0;
      psum_wr_sel <= '0;
      blk_fnh     <= 1'b0;
      err_badid   <= 1'b0;
      err_over    <= 1'b0;
    end else begin
      mac_gnt    <= gnt_nxt;
      psum_wr_en <= wr_nxt;
      for (int b = 0; b < PSUM_NUM; b++)
        if (wr_nxt[b])
          psum_wr_sel[MAC_ID_W*b +: MAC_ID_W] <= pidx[b];
      blk_fnh <= 1'b0;
      cnt     <= cnt_add;
      unique case (state)
        IDLE: begin
          if (blk_sta) begin
            state     <= RUN;
            len       <= blk_len;
            cnt       <= '0;
            err_badid <= 1'b0;
            err_over  <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_add > len) err_over  <= 1'b1;
          if (badid)         err_badid <= 1'b1;
          if (cnt >= len) begin
            state   <= DONE;
            blk_fnh <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_wr_sched.sv
// Bench for psum_wr_sched: vector table, directed corners, random vs model.
module tb_psum_wr_sched;
  import psum_wr_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic blk_sta = 1'b0;
  logic [CNT_W-1:0] blk_len = '0;
  logic [MAC_NUM-1:0] mac_req = '0;
  logic [PSUM_ID_W*MAC_NUM-1:0] mac_idpsum = '0;
  logic [PSUM_NUM-1:0] psum_rdy = '0;
  logic [MAC_NUM-1:0] mac_gnt;
  logic [PSUM_NUM-1:0] psum_wr_en;
  logic [MAC_ID_W*PSUM_NUM-1:0] psum_wr_sel;
  logic blk_fnh, err_badid, err_over;

  int n_chk = 0;
  int n_err = 0;

  psum_wr_sched dut (
    .clk         (clk),
    .rst         (rst),
    .blk_sta     (blk_sta),
    .blk_len     (blk_len),
    .mac_req     (mac_req),
    .mac_idpsum  (mac_idpsum),
    .psum_rdy    (psum_rdy),
    .mac_gnt     (mac_gnt),
    .psum_wr_en  (psum_wr_en),
    .psum_wr_sel (psum_wr_sel),
    .blk_fnh     (blk_fnh),
    .err_badid   (err_badid),
    .err_over    (err_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: block phase 0 idle, 1 run, 2 done
  int m_st, m_len, m_cnt;
  int m_ptr [PSUM_NUM];
  logic [MAC_NUM-1:0] e_gnt;
  logic [PSUM_NUM-1:0] e_wr;
  logic [MAC_ID_W*PSUM_NUM-1:0] e_sel;
  logic e_fnh, e_bad, e_over;

  task automatic m_reset();
    m_st = 0; m_len = 0; m_cnt = 0;
    foreach (m_ptr[b]) m_ptr[b] = 0;
    e_gnt = '0; e_wr = '0; e_sel = '0;
    e_fnh = 0; e_bad = 0; e_over = 0;
  endtask

  function automatic int bank_of(int i);
    return int'(mac_idpsum[PSUM_ID_W*i +: PSUM_ID_W]);
  endfunction

  task automatic m_step();
    int post, w, c;
    logic [MAC_NUM-1:0] g;
    logic [PSUM_NUM-1:0] wv;
    bit bad;
    post = m_cnt + $countones(e_wr);
    if (post > 65535) post = 65535;
    g = '0; wv = '0; bad = 0;
    for (int i = 0; i < MAC_NUM; i++)
      if (mac_req[i] && bank_of(i) >= PSUM_NUM) bad = 1;
    if (m_st == 1 && post < m_len)
      for (int b = 0; b < PSUM_NUM; b++) begin
        if (!psum_rdy[b]) continue;
        w = -1;
        for (int k = 0; k < MAC_NUM && w < 0; k++) begin
`ifdef PSUM_WR_SCHED_FIXPRI_EN
          c = k;
`else
          c = (m_ptr[b] + k) % MAC_NUM;
`endif
          if (mac_req[c] && bank_of(c) == b && !e_gnt[c]) w = c;
        end
        if (w >= 0) begin
          g[w] = 1'b1;
          wv[b] = 1'b1;
          e_sel[MAC_ID_W*b +: MAC_ID_W] = MAC_ID_W'(w);
          m_ptr[b] = (w + 1) % MAC_NUM;
        end
      end
    e_fnh = 0;
    case (m_st)
      0: begin
        m_cnt = post;
        if (blk_sta) begin
          m_st = 1; m_len = int'(blk_len); m_cnt = 0;
          e_bad = 0; e_over = 0;
        end
      end
      1: begin
        if (m_cnt >= m_len) begin m_st = 2; e_fnh = 1; end
        m_cnt = post;
        if (post > m_len) e_over = 1;
        if (bad) e_bad = 1;
      end
      default: begin m_st = 0; m_cnt = post; end
    endcase
    e_gnt = g;
    e_wr = wv;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("mdl.gnt", 64'(mac_gnt), 64'(e_gnt));
    chk("mdl.wr_en", 64'(psum_wr_en), 64'(e_wr));
    chk("mdl.wr_sel", 64'(psum_wr_sel), 64'(e_sel));
    chk("mdl.fnh", 64'(blk_fnh), 64'(e_fnh));
    chk("mdl.badid", 64'(err_badid), 64'(e_bad));
    chk("mdl.over", 64'(err_over), 64'(e_over));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) m_step();
    #1;
    cmp_model();
  endtask

  task automatic wait_fnh(string nm, int lim);
    for (int c = 0; c < lim && !blk_fnh; c++) step();
    chk(nm, 64'(blk_fnh), 64'd1);
  endtask

  task automatic set_id(int i, int b);
    mac_idpsum[PSUM_ID_W*i +: PSUM_ID_W] = PSUM_ID_W'(b);
  endtask

  typedef struct {
    bit sta; int len;
    logic [MAC_NUM-1:0] req; int bank;
    logic [PSUM_NUM-1:0] rdy;
    logic [MAC_NUM-1:0] gnt;
    logic [PSUM_NUM-1:0] wr;
    bit fnh;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit s, int l, logic [MAC_NUM-1:0] r, int bk,
                     logic [PSUM_NUM-1:0] rd, logic [MAC_NUM-1:0] g,
                     logic [PSUM_NUM-1:0] w, bit f);
    vec_t v;
    v.sta = s; v.len = l; v.req = r; v.bank = bk;
    v.rdy = rd; v.gnt = g; v.wr = w; v.fnh = f;
    tbl.push_back(v);
  endtask

  initial begin
    int order[$];
    int want[6];
    m_reset();
    psum_rdy = '1;
    repeat (2) @(posedge clk);
    #1;
    cmp_model();
    rst = 1'b0;

    // single MAC 4 -> bank 2, length 1
    add(1, 1, 27'h0,  0, 9'h1FF, 27'h0,  9'h000, 0);
    add(0, 1, 27'h10, 2, 9'h1FF, 27'h10, 9'h004, 0);
    add(0, 1, 27'h0,  2, 9'h1FF, 27'h0,  9'h000, 0);
    add(0, 1, 27'h0,  2, 9'h1FF, 27'h0,  9'h000, 1);
    add(0, 1, 27'h0,  2, 9'h1FF, 27'h0,  9'h000, 0);
    // backpressure on bank 3 for five cycles
    add(1, 1, 27'h0,  3, 9'h1FF, 27'h0,  9'h000, 0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 27'h80, 3, 9'h1F7, 27'h0, 9'h000, 0);
    add(0, 1, 27'h80, 3, 9'h1FF, 27'h80, 9'h008, 0);
    add(0, 1, 27'h0,  3, 9'h1FF, 27'h0,  9'h000, 0);
    add(0, 1, 27'h0,  3, 9'h1FF, 27'h0,  9'h000, 1);
    add(0, 1, 27'h0,  3, 9'h1FF, 27'h0,  9'h000, 0);

    foreach (tbl[n]) begin
      blk_sta = tbl[n].sta;
      blk_len = CNT_W'(tbl[n].len);
      mac_req = tbl[n].req;
      for (int i = 0; i < MAC_NUM; i++) set_id(i, tbl[n].bank);
      psum_rdy = tbl[n].rdy;
      step();
      chk($sformatf("tbl%0d.gnt", n), 64'(mac_gnt), 64'(tbl[n].gnt));
      chk($sformatf("tbl%0d.wr", n), 64'(psum_wr_en), 64'(tbl[n].wr));
      chk($sformatf("tbl%0d.fnh", n), 64'(blk_fnh), 64'(tbl[n].fnh));
    end
    blk_sta = 1'b0;
    chk("sel_bank2", 64'(psum_wr_sel[10 +: 5]), 64'd4);
    chk("sel_bank3", 64'(psum_wr_sel[15 +: 5]), 64'd7);

    // fairness: MACs 0, 9, 18 all hold requests to bank 0
`ifdef PSUM_WR_SCHED_FIXPRI_EN
    want = '{0, 9, 0, 9, 0, 9};
`else
    want = '{0, 9, 18, 0, 9, 18};
`endif
    mac_idpsum = '0;
    mac_req = '0;
    mac_req[0] = 1'b1; mac_req[9] = 1'b1; mac_req[18] = 1'b1;
    blk_sta = 1'b1; blk_len = 16'd6;
    step();
    blk_sta = 1'b0;
    for (int c = 0; c < 20 && !blk_fnh; c++) begin
      step();
      for (int i = 0; i < MAC_NUM; i++)
        if (mac_gnt[i]) order.push_back(i);
    end
    chk("rr_fnh", 64'(blk_fnh), 64'd1);
    chk("rr_count", 64'(order.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      if (k < order.size())
        chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(want[k]));
    mac_req = '0;
    step();

    // parallel: MAC i -> bank i for all nine banks
    for (int i = 0; i < PSUM_NUM; i++) set_id(i, i);
    mac_req = 27'h1FF;
    blk_sta = 1'b1; blk_len = 16'd9;
    step();
    blk_sta = 1'b0;
    step();
    chk("par_wr", 64'(psum_wr_en), 64'h1FF);
    chk("par_gnt", 64'(mac_gnt), 64'h1FF);
    mac_req = '0;
    step();
    chk("par_fnh_early", 64'(blk_fnh), 64'd0);
    step();
    chk("par_fnh", 64'(blk_fnh), 64'd1);
    step();

    // bad bank id alongside a valid request
    mac_idpsum = '0;
    set_id(2, 12); set_id(5, 1);
    mac_req = 27'h24;
    blk_sta = 1'b1; blk_len = 16'd1;
    step();
    blk_sta = 1'b0;
    step();
    chk("bad_flag", 64'(err_badid), 64'd1);
    chk("bad_gnt", 64'(mac_gnt), 64'h20);
    mac_req[5] = 1'b0;
    wait_fnh("bad_fnh", 10);
    mac_req = '0;
    step();

    // overrun: three simultaneous grants with length 2
    set_id(0, 0); set_id(1, 1); set_id(2, 2);
    mac_req = 27'h7;
    blk_sta = 1'b1; blk_len = 16'd2;
    step();
    blk_sta = 1'b0;
    chk("bad_clear", 64'(err_badid), 64'd0);
    step();
    chk("over_gnt", 64'(mac_gnt), 64'h7);
    mac_req = '0;
    step();
    chk("over_flag", 64'(err_over), 64'd1);
    wait_fnh("over_fnh", 10);
    step();

    // async reset in RUN with five writes counted
    for (int i = 0; i < 5; i++) set_id(i, i);
    mac_req = 27'h1F;
    blk_sta = 1'b1; blk_len = 16'd20;
    step();
    blk_sta = 1'b0;
    step(); step(); step();
    chk("rst_pre_gnt", 64'(mac_gnt), 64'h1F);
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", 64'(mac_gnt), 64'd0);
    chk("rst_wr", 64'(psum_wr_en), 64'd0);
    chk("rst_sel", 64'(psum_wr_sel), 64'd0);
    chk("rst_fnh", 64'(blk_fnh), 64'd0);
    m_reset();
    mac_req = '0;
    #1 rst = 1'b0;
    set_id(4, 2);
    mac_req = 27'h10;
    blk_sta = 1'b1; blk_len = 16'd1;
    step();
    blk_sta = 1'b0;
    step();
    chk("post_rst_gnt", 64'(mac_gnt), 64'h10);
    mac_req = '0;
    wait_fnh("post_rst_fnh", 10);
    step();

    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < MAC_NUM; i++) begin
        if (mac_req[i]) begin
          if (e_gnt[i]) begin
            if ($urandom_range(1, 0) == 1) mac_req[i] = 1'b0;
            else set_id(i, int'($urandom_range(PSUM_NUM-1, 0)));
          end
        end else if ($urandom_range(3, 0) == 0) begin
          mac_req[i] = 1'b1;
          set_id(i, int'($urandom_range(PSUM_NUM-1, 0)));
        end
      end
      psum_rdy = PSUM_NUM'($urandom | $urandom);
      if (m_st == 0) blk_sta = ($urandom_range(1, 0) == 1);
      else blk_sta = ($urandom_range(15, 0) == 0);
      blk_len = CNT_W'($urandom_range(30, 0));
      step();
    end
    blk_sta = 1'b0;
    mac_req = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
